bus_router: RTL and testbench

- Parametrised successor to the fixed three-target CPU bus decoder.
- Routes one CPU master to NSLAVE slaves by address-ID field.
- Supports variable-latency slaves with rvalid, up to MAX_OUTST outstanding reads, in-order return, and decode-error responses for unmapped IDs.
- Sits between the core's memory port and RAM/ROM/UART plus future peripherals.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_tag_fifo.sv | 56 +++++
 rtl/bus_router.sv | 182 ++++++++++++++++++
 tb/tb_bus_router.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants and types for the bus_router CPU bus fabric.
// Optional build macro used by bus_router: BUS_ROUTER_RESP_REG_EN.
package bus_pkg;

    localparam int RAM_ID     = 0;
    localparam int ROM_ID     = 1;
    localparam int UART_ID    = 2;
    localparam int DEF_NSLAVE = 3;

    function automatic int tgt_w(input int nslave);
        return $clog2(nslave + 1);
    endfunction

    // The decode-error pseudo-target sits one past the last real slave.
    function automatic int err_tgt(input int nslave);
        return nslave;
    endfunction

    typedef logic [tgt_w(DEF_NSLAVE)-1:0] tgt_t;

endpackage

// File: rtl/bus_tag_fifo.sv
// Tag FIFO holding the target index of each outstanding read, oldest at head.
// Pointers wrap naturally because DEPTH is a power of two.
module bus_tag_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(tgt_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_tgt,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_tgt;
        end
    end

    assign full  = (count_reg == (PW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/bus_router.sv
// Single-master CPU bus router: decodes addr[31:ID_LSB] onto NSLAVE slaves,
// tracks outstanding reads in order. Optional macro BUS_ROUTER_RESP_REG_EN.
module bus_router
    import bus_pkg::*;
#(
    parameter int NSLAVE    = DEF_NSLAVE,
    parameter int ID_LSB    = 28,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_ren,
    input  logic [31:0]          cpu_raddr,
    output logic                 cpu_rgnt,
    output logic                 cpu_rvalid,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_rerr,
    input  logic                 cpu_wen,
    input  logic [31:0]          cpu_waddr,
    input  logic [3:0]           cpu_bytemask,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_werr,
    output logic [NSLAVE-1:0]    s_ren,
    output logic [31:0]          s_raddr,
    input  logic [NSLAVE-1:0]    s_rvalid,
    input  logic [NSLAVE*32-1:0] s_rdata,
    output logic [NSLAVE-1:0]    s_wen,
    output logic [31:0]          s_waddr,
    output logic [3:0]           s_bytemask,
    output logic [31:0]          s_wdata
);

    localparam int            TW      = tgt_w(NSLAVE);
    localparam logic [TW-1:0] ERR_IDX = TW'(err_tgt(NSLAVE));

    // The ID field is compared zero-extended, so any width of field works.
    function automatic logic [TW-1:0] decode(input logic [31:0] addr);
        logic [31:0] id;
        id = addr >> ID_LSB;
        if (id < 32'(NSLAVE)) begin
            return TW'(id);
        end
        return ERR_IDX;
    endfunction

    logic [TW-1:0] rtgt;
    logic [TW-1:0] wtgt;
    logic [TW-1:0] head;
    logic [TW-1:0] last_tgt_reg;
    logic          full;
    logic          empty;
    logic          issue;
    logic          pop;
    logic          head_is_err;
    logic          head_rvalid;
    logic [31:0]   head_rdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_data;
    logic          werr_reg;

    assign rtgt = decode(cpu_raddr);
    assign wtgt = decode(cpu_waddr);

    // Only same-target reads may pile up; a target switch waits for a full drain.
    assign cpu_rgnt = !full && (empty || (rtgt == last_tgt_reg));
    assign issue    = cpu_ren && cpu_rgnt;

    genvar gi;
    generate
        for (gi = 0; gi < NSLAVE; gi++) begin : g_port
            assign s_ren[gi] = issue   && (rtgt == TW'(gi));
            assign s_wen[gi] = cpu_wen && (wtgt == TW'(gi));
        end
    endgenerate

    assign s_raddr    = cpu_raddr;
    assign s_waddr    = cpu_waddr;
    assign s_bytemask = cpu_bytemask;
    assign s_wdata    = cpu_wdata;

    bus_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (TW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (issue),
        .push_tgt (rtgt),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_comb begin
        head_rvalid = 1'b0;
        head_rdata  = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (head == TW'(i)) begin
                head_rvalid = s_rvalid[i];
                head_rdata  = s_rdata[32*i +: 32];
            end
        end
    end

    assign head_is_err = (head == ERR_IDX);
    assign pop         = !empty && (head_is_err || head_rvalid);
    assign resp_valid  = pop;
    assign resp_err    = pop && head_is_err;
    assign resp_data   = (pop && !head_is_err) ? head_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_tgt_reg <= '0;
            werr_reg     <= 1'b0;
        end else begin
            if (issue) begin
                last_tgt_reg <= rtgt;
            end
            werr_reg <= cpu_wen && (wtgt == ERR_IDX);
        end
    end

    assign cpu_werr = werr_reg;

`ifdef BUS_ROUTER_RESP_REG_EN
    logic        rvalid_reg;
    logic        rerr_reg;
    logic [31:0] rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rerr_reg   <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= resp_valid;
            rerr_reg   <= resp_err;
            rdata_reg  <= resp_data;
        end
    end

    assign cpu_rvalid = rvalid_reg;
    assign cpu_rerr   = rerr_reg;
    assign cpu_rdata  = rdata_reg;
`else
    assign cpu_rvalid = resp_valid;
    assign cpu_rerr   = resp_err;
    assign cpu_rdata  = resp_data;
`endif

`ifndef SYNTHESIS
    // Responses left over from reads in flight at reset are tolerated
    // until the first new read is issued.
    logic              stale_ok_reg;
    logic [NSLAVE-1:0] head_mask;

    always_comb begin
        head_mask = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (!empty && (head == TW'(i))) begin
                head_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_ok_reg <= 1'b1;
        end else begin
            if (issue) begin
                stale_ok_reg <= 1'b0;
            end
            if (!stale_ok_reg) begin
                assert ((s_rvalid & ~head_mask) == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router: decode vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_bus_router;
    import bus_pkg::*;

    localparam int NS     = 3;
    localparam int ID_LSB = 28;
    localparam int MAXO   = 4;
`ifdef BUS_ROUTER_RESP_REG_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cpu_ren = 1'b0;
    logic [31:0]      cpu_raddr = '0;
    logic             cpu_rgnt;
    logic             cpu_rvalid;
    logic [31:0]      cpu_rdata;
    logic             cpu_rerr;
    logic             cpu_wen = 1'b0;
    logic [31:0]      cpu_waddr = '0;
    logic [3:0]       cpu_bytemask = '0;
    logic [31:0]      cpu_wdata = '0;
    logic             cpu_werr;
    logic [NS-1:0]    s_ren;
    logic [31:0]      s_raddr;
    logic [NS-1:0]    s_rvalid = '0;
    logic [NS*32-1:0] s_rdata = '0;
    logic [NS-1:0]    s_wen;
    logic [31:0]      s_waddr;
    logic [3:0]       s_bytemask;
    logic [31:0]      s_wdata;

    always #5 clk = ~clk;

    bus_router #(.NSLAVE(NS), .ID_LSB(ID_LSB), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_rgnt(cpu_rgnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_rerr(cpu_rerr),
        .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_bytemask(cpu_bytemask),
        .cpu_wdata(cpu_wdata), .cpu_werr(cpu_werr),
        .s_ren(s_ren), .s_raddr(s_raddr), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .s_wen(s_wen), .s_waddr(s_waddr), .s_bytemask(s_bytemask), .s_wdata(s_wdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Slave environment: pending responses, each slave answers in order.
    typedef struct { int sl; int due; logic [31:0] data; } pend_t;
    pend_t pend[$];
    int    lat[NS];
    logic        fixed_en = 1'b0;
    logic [31:0] fixed_data = '0;

    // Reference model: targets of outstanding reads in issue order.
    int          outq[$];
    int          last_m = 0;
    logic        werr_m = 1'b0;
    logic        rv_pipe = 1'b0;
    logic        re_pipe = 1'b0;
    logic [31:0] rd_pipe = '0;

    logic          obs_rgnt, obs_rvalid, obs_rerr, obs_werr;
    logic [31:0]   obs_rdata;
    logic [NS-1:0] obs_sren, obs_swen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int tgt_of(input logic [31:0] a);
        int id;
        id = int'(a >> ID_LSB);
        return (id < NS) ? id : NS;
    endfunction

    // One clock cycle: called at posedge+1 with CPU inputs set; samples at negedge.
    task automatic step();
        int            drv_idx[NS];
        logic [31:0]   drv_data[NS];
        int            t, tw;
        logic          g, popped, perr, ev, ee, skip;
        logic [31:0]   pdata, ed;
        logic [NS-1:0] exp_sren, exp_swen;
        pend_t         keep[$];
        s_rvalid = '0;
        s_rdata  = '0;
        for (int i = 0; i < NS; i++) begin
            drv_idx[i]  = -1;
            drv_data[i] = '0;
            for (int k = 0; k < pend.size(); k++) begin
                if (pend[k].sl == i) begin
                    if (pend[k].due <= cyc) begin
                        drv_idx[i]          = k;
                        drv_data[i]         = pend[k].data;
                        s_rvalid[i]         = 1'b1;
                        s_rdata[32*i +: 32] = pend[k].data;
                    end
                    break;
                end
            end
        end
        #4;
        obs_rgnt = cpu_rgnt;   obs_rvalid = cpu_rvalid; obs_rerr = cpu_rerr;
        obs_werr = cpu_werr;   obs_rdata  = cpu_rdata;
        obs_sren = s_ren;      obs_swen   = s_wen;

        t = tgt_of(cpu_raddr);
        g = (outq.size() < MAXO) && (outq.size() == 0 || t == last_m);
        chk("rgnt", 32'(cpu_rgnt), 32'(g));
        exp_sren = '0;
        if (cpu_ren && g && t < NS) exp_sren[t] = 1'b1;
        chk("s_ren", 32'(s_ren), 32'(exp_sren));
        tw = tgt_of(cpu_waddr);
        exp_swen = '0;
        if (cpu_wen && tw < NS) exp_swen[tw] = 1'b1;
        chk("s_wen", 32'(s_wen), 32'(exp_swen));
        chk("werr", 32'(cpu_werr), 32'(werr_m));
        chk("s_raddr", s_raddr, cpu_raddr);
        chk("s_waddr", s_waddr, cpu_waddr);
        chk("s_wdata", s_wdata, cpu_wdata);
        chk("s_bytemask", 32'(s_bytemask), 32'(cpu_bytemask));

        popped = 1'b0; perr = 1'b0; pdata = '0;
        if (outq.size() > 0) begin
            if (outq[0] == NS) begin
                popped = 1'b1; perr = 1'b1;
            end else if (drv_idx[outq[0]] >= 0) begin
                popped = 1'b1; pdata = drv_data[outq[0]];
            end
        end
        if (RL == 0) begin ev = popped;  ee = perr;    ed = pdata;   end
        else         begin ev = rv_pipe; ee = re_pipe; ed = rd_pipe; end
        chk("rvalid", 32'(cpu_rvalid), 32'(ev));
        if (ev) begin
            chk("rdata", cpu_rdata, ed);
            chk("rerr", 32'(cpu_rerr), 32'(ee));
        end

        if (popped) void'(outq.pop_front());
        if (cpu_ren && g) begin
            outq.push_back(t);
            last_m = t;
        end
        for (int k = 0; k < pend.size(); k++) begin
            skip = 1'b0;
            for (int i = 0; i < NS; i++) if (drv_idx[i] == k) skip = 1'b1;
            if (!skip) keep.push_back(pend[k]);
        end
        pend = keep;
        for (int i = 0; i < NS; i++) begin
            if (s_ren[i]) pend.push_back('{sl: i, due: cyc + lat[i],
                                           data: fixed_en ? fixed_data : $urandom});
        end
        werr_m  = cpu_wen && (tw == NS);
        rv_pipe = popped; re_pipe = perr; rd_pipe = pdata;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        outq.delete();
        last_m = 0; werr_m = 1'b0;
        rv_pipe = 1'b0; re_pipe = 1'b0; rd_pipe = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        cpu_ren = 1'b0; cpu_wen = 1'b0;
        for (int n = 0; n < 40 && (outq.size() > 0 || pend.size() > 0); n++) step();
        step(); step();
        checks++;
        if (outq.size() > 0 || pend.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d reads still outstanding, %0d slave responses pending", outq.size(), pend.size());
        end
    endtask

    task automatic wait_resp(output int k);
        k = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (obs_rvalid) begin k = n; break; end
        end
    endtask

    typedef struct {
        logic ren; logic [31:0] raddr; logic wen; logic [31:0] waddr;
        logic [NS-1:0] sren; logic [NS-1:0] swen; logic werr;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   k, cnt, prev_nib;
        logic gr[6];
        logic [3:0] nib;
        vecs[0] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0008, 3'b001, 3'b001, 1'b0};
        vecs[1] = '{1'b1, 32'h1FFF_FFFC, 1'b1, 32'h2000_0000, 3'b010, 3'b100, 1'b0};
        vecs[2] = '{1'b1, 32'h2FFF_FFFC, 1'b1, 32'h3000_0000, 3'b100, 3'b000, 1'b1};
        vecs[3] = '{1'b1, 32'h3000_0000, 1'b1, 32'h1000_0000, 3'b000, 3'b010, 1'b0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 3'b000, 3'b000, 1'b1};
        vecs[5] = '{1'b0, 32'h1000_0000, 1'b0, 32'hF000_0000, 3'b000, 3'b000, 1'b0};
        for (int i = 0; i < NS; i++) lat[i] = 1;

        @(posedge clk); #1;
        do_reset();
        chk("rst_rgnt", 32'(obs_rgnt), 32'd1);
        chk("rst_rvalid", 32'(obs_rvalid), 32'd0);
        chk("rst_rdata", obs_rdata, 32'd0);
        chk("rst_rerr", 32'(obs_rerr), 32'd0);
        chk("rst_werr", 32'(obs_werr), 32'd0);

        for (int v = 0; v < 6; v++) begin
            cpu_ren = vecs[v].ren; cpu_raddr = vecs[v].raddr;
            cpu_wen = vecs[v].wen; cpu_waddr = vecs[v].waddr;
            cpu_wdata = $urandom; cpu_bytemask = 4'($urandom);
            step();
            chk($sformatf("vec%0d_rgnt", v), 32'(obs_rgnt), 32'd1);
            chk($sformatf("vec%0d_sren", v), 32'(obs_sren), 32'(vecs[v].sren));
            chk($sformatf("vec%0d_swen", v), 32'(obs_swen), 32'(vecs[v].swen));
            cpu_ren = 1'b0; cpu_wen = 1'b0;
            step();
            chk($sformatf("vec%0d_werr", v), 32'(obs_werr), 32'(vecs[v].werr));
            drain();
        end

        // ROM read, latency 1
        lat[ROM_ID] = 1; fixed_en = 1'b1; fixed_data = 32'hCAFE_0001;
        cpu_ren = 1'b1; cpu_raddr = 32'h1000_0010;
        step();
        chk("t1_sren", 32'(obs_sren), 32'b010);
        cpu_ren = 1'b0;
        wait_resp(k);
        chk("t1_latency", k, 1 + RL);
        chk("t1_rdata", obs_rdata, 32'hCAFE_0001);
        chk("t1_rerr", 32'(obs_rerr), 32'd0);
        fixed_en = 1'b0;
        drain();

        // Back-to-back RAM reads fill the tracker
        lat[RAM_ID] = 4;
        cpu_ren = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cpu_raddr = 32'(i * 4);
            step();
            gr[i] = obs_rgnt;
        end
        cpu_ren = 1'b0;
        chk("t2_gnt0", 32'(gr[0]), 32'd1);
        chk("t2_gnt3", 32'(gr[3]), 32'd1);
        chk("t2_gnt4_full", 32'(gr[4]), 32'd0);
        chk("t2_gnt5", 32'(gr[5]), 32'd1);
        drain();

        // RAM outstanding then UART: stall until the RAM response pops
        lat[RAM_ID] = 3;
        cpu_ren = 1'b1; cpu_raddr = 32'h0000_0100;
        step();
        cpu_raddr = 32'h2000_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            gr[i] = obs_rgnt;
            if (i == 3) chk("t3_uart_sren", 32'(obs_sren), 32'b100);
        end
        cpu_ren = 1'b0;
        chk("t3_stall0", 32'(gr[0]), 32'd0);
        chk("t3_stall_pop", 32'(gr[2]), 32'd0);
        chk("t3_issue", 32'(gr[3]), 32'd1);
        drain();

        // Unmapped read and write
        cpu_ren = 1'b1; cpu_raddr = 32'hF000_0000;
        cpu_wen = 1'b1; cpu_waddr = 32'hF000_0004;
        step();
        chk("t4_sren", 32'(obs_sren), 32'd0);
        chk("t4_swen", 32'(obs_swen), 32'd0);
        cpu_ren = 1'b0; cpu_wen = 1'b0;
        k = -1;
        for (int n = 1; n <= 3; n++) begin
            step();
            if (n == 1) chk("t4_werr_pulse", 32'(obs_werr), 32'd1);
            if (n == 2) chk("t4_werr_clear", 32'(obs_werr), 32'd0);
            if (obs_rvalid && k < 0) begin
                k = n;
                chk("t4_rerr", 32'(obs_rerr), 32'd1);
                chk("t4_rdata", obs_rdata, 32'd0);
            end
        end
        chk("t4_latency", k, 1 + RL);
        drain();

        // Reset with two RAM reads outstanding; stale responses are discarded
        lat[RAM_ID] = 3;
        cpu_ren = 1'b1; cpu_raddr = 32'h0000_0040; step();
        cpu_raddr = 32'h0000_0044; step();
        cpu_ren = 1'b0;
        do_reset();
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            if (obs_rvalid) cnt++;
        end
        chk("t5_no_rvalid", cnt, 0);
        drain();
        cpu_ren = 1'b1; cpu_raddr = 32'h0000_0080; step();
        cpu_ren = 1'b0;
        wait_resp(k);
        chk("t5_after_reset", k, 3 + RL);
        drain();

        // Randomized traffic
        prev_nib = 0;
        for (int n = 0; n < 600; n++) begin
            if (outq.size() == 0 && pend.size() == 0 && ($urandom % 8) == 0) begin
                for (int i = 0; i < NS; i++) lat[i] = 1 + int'($urandom % 4);
            end
            if (($urandom % 4) == 0) prev_nib = int'($urandom % 5);
            nib = (prev_nib == 4) ? 4'($urandom_range(3, 15)) : 4'(prev_nib);
            cpu_ren   = (($urandom % 10) < 6);
            cpu_raddr = {nib, 28'($urandom)};
            cpu_wen   = (($urandom % 10) < 3);
            cpu_waddr = {4'($urandom % 6), 28'($urandom)};
            cpu_wdata = $urandom;
            cpu_bytemask = 4'($urandom);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
